seg7_scan_driver: RTL and testbench

//   Parametrised seven-segment display driver for NUM_DIGITS hex digits. Holds a display

---
 rtl/seg7_scan_driver.sv | 173 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - parallel and time-multiplexed seven-segment display driver
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 2,
  parameter int BLINK_DIV  = 12500000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [4*NUM_DIGITS-1:0] iDIG,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic [NUM_DIGITS-1:0]   iBLINK,
  input  logic                    iLOAD,
  input  logic                    iBLANK_LZ,
  output logic [8*NUM_DIGITS-1:0] oSEG_ALL,
  output logic [7:0]              oSEG,
  output logic [NUM_DIGITS-1:0]   oDIG_EN,
  output logic                    oFRAME
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_LIM   = PW'(DEAD_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic                    EN_OFF_BIT  = (ACTIVE_LOW != 0);
  localparam logic [7:0]              SEG_OFF     = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0]   EN_OFF      = {NUM_DIGITS{EN_OFF_BIT}};
  localparam logic [8*NUM_DIGITS-1:0] SEG_ALL_OFF = {NUM_DIGITS{SEG_OFF}};

  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic                    valid_q, valid_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    bphase_q, bphase_d;
  logic [8*NUM_DIGITS-1:0] seg_all_q, seg_all_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    frame_q, frame_d;

  logic                    presc_wrap;
  logic [8*NUM_DIGITS-1:0] pat;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    lz_run;
  logic [7:0]              p;

  // Active-low g..a pattern; inverted at the end for active-high boards.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h18;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    dig_d   = dig_q;
    dp_d    = dp_q;
    blink_d = blink_q;
    valid_d = valid_q;
    if (iLOAD) begin
      dig_d   = iDIG;
      dp_d    = iDP;
      blink_d = iBLINK;
      valid_d = 1'b1;
    end

    presc_wrap = (presc_q == PRESC_LAST);
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_d = presc_wrap && (idx_q == IDX_LAST);

    bcnt_d   = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 1'b1;
    bphase_d = bphase_q ^ (bcnt_q == BLINK_LAST);
  end

  // Leading-zero run is tracked from the most significant digit downward.
  always_comb begin
    pat    = SEG_ALL_OFF;
    lz     = '0;
    lz_run = 1'b1;
    p      = 8'hFF;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run & (dig_q[4*k +: 4] == 4'h0);
      lz[k]  = lz_run;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      p = {~dp_q[k], hex_to_seg(dig_q[4*k +: 4])};
      if (iBLANK_LZ && lz[k] && (k != 0)) begin
        p[6:0] = 7'h7F;
      end
      if ((bphase_q && blink_q[k]) || !valid_q) begin
        p = 8'hFF;
      end
      pat[8*k +: 8] = (ACTIVE_LOW != 0) ? p : ~p;
    end
  end

  // Scan outputs are computed from the next index/prescaler so they line up with them.
  always_comb begin
    seg_all_d = pat;
    seg_d     = SEG_OFF;
    en_d      = EN_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        seg_d = pat[8*k +: 8];
        if (valid_q && (presc_d >= DEAD_LIM)) begin
          en_d[k] = ~EN_OFF_BIT;
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dig_q     <= '0;
      dp_q      <= '0;
      blink_q   <= '0;
      valid_q   <= 1'b0;
      presc_q   <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      bphase_q  <= 1'b0;
      seg_all_q <= SEG_ALL_OFF;
      seg_q     <= SEG_OFF;
      en_q      <= EN_OFF;
      frame_q   <= 1'b0;
    end else begin
      dig_q     <= dig_d;
      dp_q      <= dp_d;
      blink_q   <= blink_d;
      valid_q   <= valid_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      bphase_q  <= bphase_d;
      seg_all_q <= seg_all_d;
      seg_q     <= seg_d;
      en_q      <= en_d;
      frame_q   <= frame_d;
    end
  end

  assign oSEG_ALL = seg_all_q;
  assign oSEG     = seg_q;
  assign oDIG_EN  = en_q;
  assign oFRAME   = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] dig;
  logic [5:0]  dp;
  logic [5:0]  blink;
  logic        load;
  logic        blz;
  logic [47:0] seg_all;
  logic [7:0]  seg;
  logic [5:0]  dig_en;
  logic        frame;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  typedef struct {
    string       name;
    logic [23:0] dig;
    logic [5:0]  dp;
    logic        blz;
    logic [47:0] exp_all;
  } vec_t;

  vec_t        vecs[$];
  logic [47:0] exp_q[$];

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] scan_tab [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

  always #5 clk = ~clk;

  // Edges since reset release; tracks the free-running blink timebase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  seg7_scan_driver #(
    .NUM_DIGITS(6),
    .SCAN_DIV  (8),
    .DEAD_CYC  (2),
    .BLINK_DIV (4),
    .ACTIVE_LOW(1)
  ) dut (
    .iCLK     (clk),
    .iRST_N   (rst_n),
    .iDIG     (dig),
    .iDP      (dp),
    .iBLINK   (blink),
    .iLOAD    (load),
    .iBLANK_LZ(blz),
    .oSEG_ALL (seg_all),
    .oSEG     (seg),
    .oDIG_EN  (dig_en),
    .oFRAME   (frame)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    dig  = v.dig;
    dp   = v.dp;
    blz  = v.blz;
    load = 1'b1;
    exp_q.push_back(v.exp_all);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    if (exp_q.size() == 0) check({v.name, "_sb_empty"}, 64'd0, 64'd1);
    else                   check(v.name, seg_all, exp_q.pop_front());
  endtask

  function automatic vec_t mk(input string n, input logic [23:0] d, input logic [5:0] p,
                              input logic b, input logic [47:0] e);
    vec_t v;
    v.name = n; v.dig = d; v.dp = p; v.blz = b; v.exp_all = e;
    return v;
  endfunction

  initial begin
    logic        found;
    logic [5:0]  exp_en;
    logic [7:0]  exp_d0;
    int          s;
    int          ph;

    rst_n = 1'b0; dig = '0; dp = '0; blink = '0; load = 1'b0; blz = 1'b0;

    vecs.push_back(mk("T3_lz_400",   24'h000400, 6'h00, 1'b1, 48'hFFFFFF99C0C0));
    vecs.push_back(mk("T3_lz_zero",  24'h000000, 6'h00, 1'b1, 48'hFFFFFFFFFFC0));
    vecs.push_back(mk("T3_nolz_400", 24'h000400, 6'h00, 1'b0, 48'hC0C0C099C0C0));
    vecs.push_back(mk("T3_nolz_0",   24'h000000, 6'h00, 1'b0, 48'hC0C0C0C0C0C0));
    vecs.push_back(mk("T3_lz_dp",    24'h000000, 6'h21, 1'b1, 48'h7FFFFFFFFF40));
    vecs.push_back(mk("T3_lz_F0000", 24'h0F0000, 6'h00, 1'b1, 48'hFF8EC0C0C0C0));
    vecs.push_back(mk("hex_ABCDEF",  24'hABCDEF, 6'h00, 1'b1, 48'h8883C6A1868E));
    for (int c = 0; c < 16; c++) begin
      vecs.push_back(mk($sformatf("T2_code_%0h", c), 24'(c), 6'h01, 1'b0,
                        {40'hC0C0C0C0C0, seg_tab[c] & 8'h7F}));
    end

    repeat (3) @(negedge clk);
    check("rst_seg_all", seg_all, 48'hFFFFFFFFFFFF);
    check("rst_seg",     seg,     8'hFF);
    check("rst_dig_en",  dig_en,  6'h3F);
    check("rst_frame",   frame,   1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("preload_seg_all", seg_all, 48'hFFFFFFFFFFFF);
      check("preload_dig_en",  dig_en,  6'h3F);
    end

    // T1: one-cycle load latency
    dig = 24'h123456; dp = 6'h00; blz = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("T1_latency", seg_all, 48'hFFFFFFFFFFFF);
    @(negedge clk);
    check("T1_load", seg_all, 48'hF9A4B0999282);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // T4: scan order, dead time and frame period
    apply_vec(mk("T4_reload", 24'h123456, 6'h00, 1'b0, 48'hF9A4B0999282));
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (frame) found = 1'b1;
    end
    check("T4_frame_seen", found, 1'b1);
    if (found) begin
      for (int c = 0; c <= 48; c++) begin
        if (c > 0) @(negedge clk);
        s = (c / 8) % 6;
        exp_en = ((c % 8) < 2) ? 6'h3F : ~(6'b000001 << s);
        check($sformatf("T4_en_c%0d", c),    dig_en, exp_en);
        check($sformatf("T4_seg_c%0d", c),   seg,    scan_tab[s]);
        check($sformatf("T4_frame_c%0d", c), frame,  (c % 48) == 0);
      end
    end

    // T5: blink digit 0 only
    @(negedge clk);
    dig = 24'h000008; dp = 6'h00; blink = 6'h01; blz = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0; blink = 6'h00;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      ph = ((cyc - 1) / 4) % 2;
      exp_d0 = (ph != 0) ? 8'hFF : 8'h80;
      check($sformatf("T5_d0_%0d", i),    seg_all[7:0],  exp_d0);
      check($sformatf("T5_upper_%0d", i), seg_all[47:8], 40'hC0C0C0C0C0);
      @(negedge clk);
    end

    // T6: asynchronous reset mid-slot with a load pending
    @(posedge clk);
    #2;
    dig = 24'h777777; load = 1'b1; rst_n = 1'b0;
    #1;
    check("T6_async_seg_all", seg_all, 48'hFFFFFFFFFFFF);
    check("T6_async_seg",     seg,     8'hFF);
    check("T6_async_dig_en",  dig_en,  6'h3F);
    check("T6_async_frame",   frame,   1'b0);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) begin
        check("T6_post_seg_all", seg_all, 48'hFFFFFFFFFFFF);
        check("T6_post_dig_en",  dig_en,  6'h3F);
      end
    end
    apply_vec(mk("T6_reload", 24'h777777, 6'h00, 1'b0, 48'hF8F8F8F8F8F8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
